mux_scan_ctrl: RTL
==================

Name: mux_scan_ctrl

Overview:
Sequencer that sits directly upstream of the 10:1 enable-high mux and also consumes its output.
- Drives the mux select S and enable E, stepping through channels 0..9.
- Holds each channel for a programmable dwell time and samples the mux output Y at the end of each dwell.
- Presents the 10 sampled bits as one result word through a valid/ready handshake.
- Supports single-shot and continuous scanning.

Parameters:
NUM_CH, 10, number of mux channels scanned (1..16).
DWELL, 4, cycles S is held per channel (>=1); Y is sampled on the last dwell cycle.

Ports:
clk  in  1  single clock, all logic on rising edge.
rst_n  in  1  synchronous, active-low reset.
start  in  1  begin a scan; sampled only in IDLE.
cont  in  1  continuous mode; sampled when the result handshake completes.
abort  in  1  return to IDLE next cycle from any state.
y_in  in  1  mux output Y (combinational from S/E).
S  out  4  mux select, equal to the current channel.
E  out  1  mux enable, high only while scanning.
busy  out  1  high in SCAN and HOLD.
result  out  NUM_CH  sampled bits; bit n = Y while S=n.
result_valid  out  1  result available.
result_ready  in  1  consumer accepts result.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values (rst_n=0 at an edge): state=IDLE, S=0, E=0, busy=0, result=0, result_valid=0. Dwell counter and channel counter are 0. Reset mid-scan discards the partial sample.

States:
- IDLE: E=0, S=0, busy=0.
  - start=1 -> SCAN with ch=0, dcnt=0.
- SCAN: E=1, S=ch, busy=1.
  - dcnt increments each cycle.
  - At dcnt==DWELL-1: shadow[ch]<=y_in and dcnt<=0.
    - If ch<NUM_CH-1: ch<=ch+1.
    - If ch==NUM_CH-1: result<=shadow with the final bit merged, result_valid<=1, go to HOLD.
- HOLD: E=0, S=0, busy=1, result_valid=1. result is stable.
  - result_ready=1 -> result_valid<=0.
    - If cont=1: SCAN with ch=0, dcnt=0.
    - Else: IDLE.

Timing:
- From the start edge, E is high for exactly NUM_CH*DWELL cycles.
- result_valid rises on the same edge that drops E, i.e. NUM_CH*DWELL cycles after start is sampled.
- In continuous mode, E rises the edge after the handshake, so there is no dead cycle beyond HOLD.

Boundary conditions:
- start while busy: ignored.
- start and abort in the same cycle: abort wins.
- abort in any state: IDLE next edge, result_valid<=0, E<=0. result keeps its last completed value and shadow is cleared.
- result_ready with result_valid=0: ignored.
- DWELL=1: one channel per cycle, sampled the same cycle S is presented.
- ch counter is 4 bits; it never exceeds NUM_CH-1 and wraps to 0 only via HOLD.

Decomposition:
- Shared package holds: state encoding (IDLE=2'd0, SCAN=2'd1, HOLD=2'd2); constants NUM_CH_DEF=10, SEL_W=4, DWELL_DEF=4.
- One sub-module, dwell_counter: parameter DWELL; inputs clk, rst_n, clr, en; output last (asserted at count DWELL-1, then wraps to 0).
- The FSM, channel counter and shadow/result registers stay in the top module.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles mid-scan -> S=0, E=0, busy=0, result_valid=0, result=0 on the first edge after reset.
2. Single-shot, DWELL=4, y_in driven as a model mux over a fixed I=10'b1011001110, cont=0:
   - E high for 40 cycles, S steps 0..9 every 4 cycles.
   - result=10'b1011001110, result_valid=1 on cycle 40.
   - result_ready=1 for one cycle -> IDLE, busy=0.
3. Backpressure: hold result_ready=0 for 20 cycles after completion -> result_valid and result remain stable, E=0, a start pulse is ignored. Asserting ready completes the handshake.
4. Continuous mode with cont=1, I changed to 10'b0101010101 during HOLD:
   - The second scan starts the edge after the handshake.
   - Second result=10'b0101010101.
   - Over the two scans E is low for exactly 1 cycle between them.
5. Abort at channel 5, dwell cycle 2 -> IDLE next edge, E=0, result unchanged from the prior scan, result_valid=0. A new start gives a clean full scan.
6. DWELL=1 build with I toggling: S advances every cycle, result_valid after 10 cycles, and each result bit matches I[n] at its sample cycle.

Source files
------------

// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux scan sequencer: FSM encoding and default sizing.
package mux_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int NUM_CH_DEF = 10;
   localparam int SEL_W      = 4;
   localparam int DWELL_DEF  = 4;

endpackage

// File: rtl/mux_scan_ctrl_dwell_counter.sv
// Counts the cycles a channel is held; last marks the final dwell cycle, then the count wraps.
module dwell_counter #(
   parameter int DWELL = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic last
);

   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= last ? '0 : cnt + 1'b1;
      end
   end

   assign last = (cnt == LAST_CNT);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans an enable-high mux channel by channel, samples its output per channel and hands the word off via valid/ready.
module mux_scan_ctrl
   import mux_scan_ctrl_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int DWELL  = DWELL_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              cont,
   input  logic              abort,
   input  logic              y_in,
   output logic [SEL_W-1:0]  S,
   output logic              E,
   output logic              busy,
   output logic [NUM_CH-1:0] result,
   output logic              result_valid,
   input  logic              result_ready
);

   localparam logic [SEL_W-1:0] CH_MAX = SEL_W'(NUM_CH - 1);

   state_t            state;
   state_t            state_next;
   logic [SEL_W-1:0]  ch;
   logic [NUM_CH-1:0] shadow;
   logic [NUM_CH-1:0] merged;
   logic              last;
   logic              dwell_done;
   logic              ch_last;

   dwell_counter #(.DWELL(DWELL)) u_dwell (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   ((state != SCAN) || abort),
      .en    (state == SCAN),
      .last  (last)
   );

   assign dwell_done = (state == SCAN) && last;
   assign ch_last    = (ch == CH_MAX);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = SCAN;
         SCAN:    if (dwell_done && ch_last) state_next = HOLD;
         HOLD:    if (result_ready) state_next = cont ? SCAN : IDLE;
         default: state_next = IDLE;
      endcase
      if (abort) begin
         state_next = IDLE;
      end
   end

   // The final channel's bit is merged combinationally so result is complete on the edge that enters HOLD.
   always_comb begin
      merged     = shadow;
      merged[ch] = y_in;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ch     <= '0;
         shadow <= '0;
         result <= '0;
      end else if (abort) begin
         ch     <= '0;
         shadow <= '0;
      end else begin
         case (state)
            IDLE: ch <= '0;
            SCAN: begin
               if (dwell_done) begin
                  shadow <= merged;
                  if (ch_last) begin
                     result <= merged;
                  end else begin
                     ch <= ch + 1'b1;
                  end
               end
            end
            HOLD: if (result_ready) ch <= '0;
            default: ch <= '0;
         endcase
      end
   end

   assign E            = (state == SCAN);
   assign S            = (state == SCAN) ? ch : '0;
   assign busy         = (state != IDLE);
   assign result_valid = (state == HOLD);

endmodule
